// File: rtl/gray_step_tracker.sv
// gray_step_tracker: synchronises a 2-bit Gray code into the clk domain.
// Each code change is classified as a forward step, a backward step or an
// illegal double-bit jump, and a wrapping signed position count is kept.
// Illegal jumps raise a sticky fault that holds until err_clr is seen.
module gray_step_tracker #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             g1,
   input  logic             g0,
   input  logic             en,
   input  logic             clr,
   input  logic             err_clr,
   output logic [CNT_W-1:0] pos,
   output logic             step_up,
   output logic             step_dn,
   output logic             err,
   output logic             fault
);

   // Enough bits to count 0..SYNC_STAGES while settling after reset.
   localparam int INIT_W = $clog2(SYNC_STAGES + 1);
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [INIT_W-1:0]    init_cnt, init_cnt_nxt;
   logic [SYNC_STAGES-1:0] sync1, sync0;
   logic                 s1, s0;
   logic [1:0]           idx, prev, delta;
   logic [CNT_W-1:0]     pos_nxt;
   logic                 step_up_nxt, step_dn_nxt, err_nxt;

   // Synchronise each Gray bit through SYNC_STAGES flops; the MSB of each
   // shift register is the oldest and therefore the settled sample.
   // NOTE: every clocked block uses non-blocking assignments so all flops
   // sample pre-edge values and the chain shifts by exactly one stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync0 <= '0;
      end else begin
         sync1 <= {sync1[SYNC_STAGES-2:0], g1};
         sync0 <= {sync0[SYNC_STAGES-2:0], g0};
      end
   end

   assign s1 = sync1[SYNC_STAGES-1];
   assign s0 = sync0[SYNC_STAGES-1];

   // Gray to binary: forward order 00,01,11,10 maps to idx 0,1,2,3.
   assign idx   = {s1, s1 ^ s0};
   assign delta = idx - prev;

   // State register and post-reset settle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
      end
   end

   // Next-state, step classification and next position.
   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      pos_nxt      = pos;
      step_up_nxt  = 1'b0;
      step_dn_nxt  = 1'b0;
      err_nxt      = 1'b0;

      case (state)
         ST_INIT: begin
            // Let the synchroniser flush whatever code sat on the pins.
            if (init_cnt == INIT_LAST) state_nxt = ST_TRACK;
            else                       init_cnt_nxt = init_cnt + INIT_W'(1);
         end
         ST_TRACK: begin
            if (en) begin
               case (delta)
                  2'd1: begin
                     step_up_nxt = 1'b1;
                     pos_nxt     = pos + CNT_W'(1);
                  end
                  2'd3: begin
                     step_dn_nxt = 1'b1;
                     pos_nxt     = pos - CNT_W'(1);
                  end
                  2'd2: begin
                     err_nxt   = 1'b1;
                     state_nxt = ST_FAULT;
                  end
                  default: ;
               endcase
            end
         end
         ST_FAULT: begin
            // prev keeps tracking here, so returning to TRACK is clean.
            if (err_clr) state_nxt = ST_TRACK;
         end
         default: state_nxt = ST_INIT;
      endcase

      // Clear wins over any step counted in the same cycle.
      if (clr) pos_nxt = '0;
   end

   // Registered position, last accepted index and one-cycle strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev    <= 2'd0;
         pos     <= '0;
         step_up <= 1'b0;
         step_dn <= 1'b0;
         err     <= 1'b0;
      end else begin
         prev    <= idx;
         pos     <= pos_nxt;
         step_up <= step_up_nxt;
         step_dn <= step_dn_nxt;
         err     <= err_nxt;
      end
   end

   assign fault = (state == ST_FAULT);

endmodule

// File: tb/tb_gray_step_tracker.sv
// Directed bench for gray_step_tracker (CNT_W=16, SYNC_STAGES=2).
// Pins change 1 time unit after a rising edge; a change is reported on the
// third rising edge after it, and outputs are sampled 1 unit after edges.
module tb_gray_step_tracker;

   logic        clk;
   logic        rst;
   logic        g1;
   logic        g0;
   logic        en;
   logic        clr;
   logic        err_clr;
   logic [15:0] pos;
   logic        step_up;
   logic        step_dn;
   logic        err;
   logic        fault;

   int checks = 0;
   int errors = 0;

   gray_step_tracker #(.CNT_W(16), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .g1      (g1),
      .g0      (g0),
      .en      (en),
      .clr     (clr),
      .err_clr (err_clr),
      .pos     (pos),
      .step_up (step_up),
      .step_dn (step_dn),
      .err     (err),
      .fault   (fault)
   );

   // 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence never completes.
   initial begin
      #200000;
      $display("FAIL timeout: sequence did not complete");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic quiet(input string tag);
      chk1({tag, ".up"},  step_up, 1'b0);
      chk1({tag, ".dn"},  step_dn, 1'b0);
      chk1({tag, ".err"}, err,     1'b0);
   endtask

   // Apply a new pin code and follow it through 4 edges: quiet, quiet,
   // expected strobes/pos/fault, quiet again.
   task automatic step(input string tag, input logic ng1, input logic ng0,
                       input logic eu, input logic ed, input logic ee,
                       input logic [15:0] ep, input logic ef);
      g1 = ng1;
      g0 = ng0;
      tick();
      quiet({tag, ".e1"});
      tick();
      quiet({tag, ".e2"});
      tick();
      chk1 ({tag, ".up"},    step_up, eu);
      chk1 ({tag, ".dn"},    step_dn, ed);
      chk1 ({tag, ".err"},   err,     ee);
      chk16({tag, ".pos"},   pos,     ep);
      chk1 ({tag, ".fault"}, fault,   ef);
      tick();
      quiet({tag, ".e4"});
      chk16({tag, ".pos4"},  pos,     ep);
   endtask

   initial begin
      rst = 1'b1; g1 = 1'b1; g0 = 1'b1;
      en = 1'b1; clr = 1'b0; err_clr = 1'b0;

      // Reset with code 11 on the pins.
      repeat (3) tick();
      chk16("rst.pos", pos, 16'h0000);
      quiet("rst");
      chk1("rst.fault", fault, 1'b0);

      // Release: the static 11 must be absorbed silently.
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         quiet("init11");
      end
      chk16("init11.pos",   pos,   16'h0000);
      chk1 ("init11.fault", fault, 1'b0);

      // Two backward steps from 11 (idx 2): 01, 00.
      step("bk1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0);
      step("bk2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0);
      clr = 1'b1; tick(); clr = 1'b0;
      chk16("clr1.pos", pos, 16'h0000);

      // Full forward cycle 00->01->11->10->00.
      step("fw1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0);
      step("fw2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0);
      step("fw3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0);
      step("fw4", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0);
      clr = 1'b1; tick(); clr = 1'b0;
      chk16("clr2.pos", pos, 16'h0000);

      // Underflow to all ones, then wrap back to zero.
      step("wrapdn", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0);
      step("wrapup", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

      // Illegal jump 01->10 raises err and fault, pos held.
      step("pre",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0);
      step("jump", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1);
      step("flt1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1);
      step("flt2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1);

      // err_clr: fault drops one edge later with no spurious strobe.
      err_clr = 1'b1;
      chk1("eclr.before", fault, 1'b1);
      tick();
      err_clr = 1'b0;
      chk1("eclr.after", fault, 1'b0);
      quiet("eclr");
      tick();
      quiet("eclr2");
      step("resume", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0);

      // clr coincident with a detected forward step 11->10.
      g1 = 1'b1; g0 = 1'b0;
      tick(); quiet("cs.e1");
      tick(); quiet("cs.e2");
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk1 ("cs.up",  step_up, 1'b1);
      chk16("cs.pos", pos,     16'h0000);
      tick();
      chk1 ("cs.up4",  step_up, 1'b0);
      chk16("cs.pos4", pos,     16'h0000);

      // en low: steps and even a double jump are ignored.
      en = 1'b0;
      step("dis1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      step("dis2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      step("dis3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      en = 1'b1;

      // Count up to 7 from 10 (idx 3).
      step("u1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0);
      step("u2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0);
      step("u3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0);
      step("u4", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0);
      step("u5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5, 1'b0);
      step("u6", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd6, 1'b0);
      step("u7", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7, 1'b0);

      // Jump 11->00 at pos 7, then reset mid-cycle while err is high.
      g1 = 1'b0; g0 = 1'b0;
      tick(); tick(); tick();
      chk1 ("j7.err",   err,   1'b1);
      chk1 ("j7.fault", fault, 1'b1);
      chk16("j7.pos",   pos,   16'd7);
      #2 rst = 1'b1;
      #1;
      chk16("arst.pos",   pos,   16'h0000);
      chk1 ("arst.err",   err,   1'b0);
      chk1 ("arst.up",    step_up, 1'b0);
      chk1 ("arst.fault", fault, 1'b0);
      g1 = 1'b1; g0 = 1'b1;
      tick(); tick();

      // Release with 11 held; a change to 10 after the first edge counts
      // on the fourth edge, nothing before.
      rst = 1'b0;
      tick();
      quiet("ri.e1");
      g1 = 1'b1; g0 = 1'b0;
      tick(); quiet("ri.e2");
      tick(); quiet("ri.e3");
      tick();
      chk1 ("ri.up",    step_up, 1'b1);
      chk1 ("ri.err",   err,     1'b0);
      chk16("ri.pos",   pos,     16'd1);
      chk1 ("ri.fault", fault,   1'b0);
      tick();
      quiet("ri.e5");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
